// File: rtl/lcd_pkg.sv
// lcd_pkg: ILI9341 command bytes and rectangle-painter state encoding.
package lcd_pkg;
  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_PASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;
  typedef enum logic [3:0] {
    IDLE, SETTLE, CASET, XDATA, PASET, YDATA, RAMWR, PIXELS, FINISH
  } state_t;
endpackage

// File: rtl/spi_byte_tx.sv
// spi_byte_tx: mode-0 SPI byte shifter, MSB first, accepts the next byte on o_last for gapless streaming.
module spi_byte_tx #(
  parameter int CLK_DIV = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_valid,
  input  logic [7:0] i_byte,
  output logic       o_ready,
  output logic       o_sclk,
  output logic       o_mosi,
  output logic       o_last
);
  localparam int PW = $clog2(2 * CLK_DIV);
  logic          busy;
  logic          wrap;
  logic [7:0]    sh;
  logic [2:0]    bit_n;
  logic [PW-1:0] ph;
  always_comb begin
    wrap    = ph == PW'(2 * CLK_DIV - 1);
    o_last  = busy && wrap && bit_n == 3'd7;
    o_ready = !busy || o_last;
    o_sclk  = busy && ph >= PW'(CLK_DIV);
    o_mosi  = sh[7];
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      busy  <= 1'b0;
      sh    <= '0;
      bit_n <= '0;
      ph    <= '0;
    end else if (i_valid && o_ready) begin
      busy  <= 1'b1;
      sh    <= i_byte;
      bit_n <= '0;
      ph    <= '0;
    end else if (busy) begin
      ph <= wrap ? '0 : ph + 1'b1;
      if (wrap) begin
        sh    <= sh << 1;
        bit_n <= bit_n + 1'b1;
      end
      if (o_last) busy <= 1'b0;
    end
  end
endmodule

// File: rtl/spi_rect_fill.sv
// spi_rect_fill: streams CASET/PASET/RAMWR and pixel data for one filled or outlined rectangle over SPI.
module spi_rect_fill
  import lcd_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int COORD_W = 9,
  parameter int COLOR_W = 16,
  parameter int DELAY   = 20
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [COORD_W-1:0] i_x1,
  input  logic [COORD_W-1:0] i_x2,
  input  logic [COORD_W-1:0] i_y1,
  input  logic [COORD_W-1:0] i_y2,
  input  logic [COLOR_W-1:0] i_fg,
  input  logic [COLOR_W-1:0] i_bg,
  input  logic               i_mode,
  output logic               o_sclk,
  output logic               o_mosi,
  output logic               o_dc,
  output logic               o_cs,
  output logic               o_busy,
  output logic               o_done
);
  localparam int NB  = COLOR_W / 8;
  localparam int PBW = NB > 1 ? $clog2(NB) : 1;
  localparam int DW  = $clog2(DELAY + 1);
  state_t state, state_n;
  logic [COORD_W-1:0] x1, x2, y1, y2, col, row;
  logic [COLOR_W-1:0] fg, bg, pix, pix_sh;
  logic               mode, tx_valid, tx_ready, tx_last, fire, last_pix, edge_px;
  logic               dc_q, cs_q, busy_q, done_q;
  logic [1:0]         idx;
  logic [PBW-1:0]     pb;
  logic [DW-1:0]      dly;
  logic [15:0]        coord;
  logic [7:0]         tx_byte;
  spi_byte_tx #(.CLK_DIV(CLK_DIV)) u_tx (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(tx_valid), .i_byte(tx_byte),
    .o_ready(tx_ready), .o_sclk(o_sclk), .o_mosi(o_mosi), .o_last(tx_last)
  );
  // state names the next byte to hand the shifter; it advances whenever that byte is taken
  always_comb begin
    coord    = 16'(state == XDATA ? (idx[1] ? x2 : x1) : (idx[1] ? y2 : y1));
    edge_px  = col == x1 || col == x2 || row == y1 || row == y2;
    pix      = mode && !edge_px ? bg : fg;
    pix_sh   = pix >> (8 * (NB - 1 - int'(pb)));
    last_pix = col == x2 && row == y2;
    tx_valid = state inside {CASET, XDATA, PASET, YDATA, RAMWR, PIXELS};
    tx_byte  = state == CASET ? CMD_CASET :
               state == PASET ? CMD_PASET :
               state == RAMWR ? CMD_RAMWR :
               (state == XDATA || state == YDATA) ? (idx[0] ? coord[7:0] : coord[15:8]) :
               pix_sh[7:0];
    fire     = tx_valid && tx_ready;
    state_n  = state;
    case (state)
      IDLE:    if (i_start && !done_q) state_n = SETTLE;
      SETTLE:  if (dly == DW'(DELAY - 1)) state_n = CASET;
      CASET:   if (fire) state_n = XDATA;
      XDATA:   if (fire && idx == 2'd3) state_n = PASET;
      PASET:   if (fire) state_n = YDATA;
      YDATA:   if (fire && idx == 2'd3) state_n = RAMWR;
      RAMWR:   if (fire) state_n = PIXELS;
      PIXELS:  if (fire && pb == PBW'(NB - 1) && last_pix) state_n = FINISH;
      FINISH:  if (tx_ready && !tx_last) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) state <= i_rst ? IDLE : state_n;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      dly    <= '0;
      idx    <= '0;
      pb     <= '0;
      dc_q   <= 1'b0;
      cs_q   <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= state == FINISH && state_n == IDLE;
      cs_q   <= state_n == IDLE;
      busy_q <= state_n != IDLE;
      dly    <= state == SETTLE ? dly + 1'b1 : '0;
      if (state == IDLE && state_n == SETTLE) begin
        x1   <= i_x1 > i_x2 ? i_x2 : i_x1;
        x2   <= i_x1 > i_x2 ? i_x1 : i_x2;
        y1   <= i_y1 > i_y2 ? i_y2 : i_y1;
        y2   <= i_y1 > i_y2 ? i_y1 : i_y2;
        col  <= i_x1 > i_x2 ? i_x2 : i_x1;
        row  <= i_y1 > i_y2 ? i_y2 : i_y1;
        fg   <= i_fg;
        bg   <= i_bg;
        mode <= i_mode;
      end
      if (fire) begin
        dc_q <= !(state inside {CASET, PASET, RAMWR});
        idx  <= (state == XDATA || state == YDATA) ? idx + 1'b1 : 2'd0;
        if (state == PIXELS) begin
          pb <= pb == PBW'(NB - 1) ? '0 : pb + 1'b1;
          if (pb == PBW'(NB - 1)) begin
            col <= col == x2 ? x1 : col + 1'b1;
            if (col == x2) row <= row + 1'b1;
          end
        end
      end
    end
  end
  always_comb begin
    o_dc   = dc_q;
    o_cs   = cs_q;
    o_busy = busy_q;
    o_done = done_q;
  end
endmodule

// File: tb/tb_spi_rect_fill.sv
// tb_spi_rect_fill: scoreboard bench decoding the SPI stream byte by byte against a rectangle model.
module tb_spi_rect_fill;
  logic        clk = 0, rst = 1, start = 0, mode = 0;
  logic [8:0]  x1 = 0, x2 = 0, y1 = 0, y2 = 0;
  logic [15:0] fg = 0, bg = 0;
  logic        sclk, mosi, dc, cs, busy, done;
  int          errors = 0, checks = 0, edges = 0, dones = 0, nbits = 0, e = 0;
  logic [7:0]  shreg = 0;
  logic        byte_dc = 0, prev_sclk = 0;
  logic [8:0]  exp_q[$];

  always #5 clk = ~clk;

  spi_rect_fill #(.CLK_DIV(2), .COORD_W(9), .COLOR_W(16), .DELAY(20)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_x1(x1), .i_x2(x2), .i_y1(y1), .i_y2(y2),
    .i_fg(fg), .i_bg(bg), .i_mode(mode), .o_sclk(sclk), .o_mosi(mosi), .o_dc(dc),
    .o_cs(cs), .o_busy(busy), .o_done(done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_rect(input logic [8:0] a_x1, a_x2, a_y1, a_y2, input logic [15:0] f, b,
                           input logic m, output int n);
    logic [8:0]  lx, hx, ly, hy;
    logic [15:0] p;
    lx = a_x1 < a_x2 ? a_x1 : a_x2;
    hx = a_x1 < a_x2 ? a_x2 : a_x1;
    ly = a_y1 < a_y2 ? a_y1 : a_y2;
    hy = a_y1 < a_y2 ? a_y2 : a_y1;
    exp_q.push_back({1'b0, 8'h2A});
    exp_q.push_back({1'b1, 7'b0, lx[8]}); exp_q.push_back({1'b1, lx[7:0]});
    exp_q.push_back({1'b1, 7'b0, hx[8]}); exp_q.push_back({1'b1, hx[7:0]});
    exp_q.push_back({1'b0, 8'h2B});
    exp_q.push_back({1'b1, 7'b0, ly[8]}); exp_q.push_back({1'b1, ly[7:0]});
    exp_q.push_back({1'b1, 7'b0, hy[8]}); exp_q.push_back({1'b1, hy[7:0]});
    exp_q.push_back({1'b0, 8'h2C});
    for (int r = int'(ly); r <= int'(hy); r++)
      for (int c = int'(lx); c <= int'(hx); c++) begin
        p = (!m || c == int'(lx) || c == int'(hx) || r == int'(ly) || r == int'(hy)) ? f : b;
        exp_q.push_back({1'b1, p[15:8]});
        exp_q.push_back({1'b1, p[7:0]});
      end
    n = (int'(hx) - int'(lx) + 1) * (int'(hy) - int'(ly) + 1);
  endtask

  task automatic start_rect(input logic [8:0] a_x1, a_x2, a_y1, a_y2, input logic [15:0] f, b,
                            input logic m, output int exp_edges);
    int n;
    push_rect(a_x1, a_x2, a_y1, a_y2, f, b, m, n);
    exp_edges = 8 * (11 + n * 2);
    x1 = a_x1; x2 = a_x2; y1 = a_y1; y2 = a_y2; fg = f; bg = b; mode = m;
    edges = 0; dones = 0; start = 1;
    @(negedge clk);
    start = 0;
    check("busy_rise", busy, 1);
    check("cs_fall", cs, 0);
  endtask

  task automatic wait_done(input string tag, input int exp_edges, input logic poke);
    int t = 0;
    while (done !== 1'b1 && t < 30000) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_done_seen"}, done, 1);
    check({tag, "_busy_fall"}, busy, 0);
    check({tag, "_cs_rise"}, cs, 1);
    if (poke) begin
      x1 = 9'd100; x2 = 9'd101; y1 = 9'd100; y2 = 9'd101; start = 1;
    end
    @(negedge clk);
    start = 0;
    check({tag, "_sclk_edges"}, edges, exp_edges);
    check({tag, "_done_count"}, dones, 1);
    check({tag, "_bytes_left"}, exp_q.size(), 0);
  endtask

  // decode one byte per 8 SCLK rising edges; dc is captured at the first edge of each byte
  always @(negedge clk) begin
    if (rst) begin
      nbits = 0;
      prev_sclk = 0;
    end else begin
      if (done) dones++;
      if (sclk && !prev_sclk) begin
        edges++;
        check("cs_low_on_sclk", cs, 0);
        if (nbits == 0) byte_dc = dc;
        shreg = {shreg[6:0], mosi};
        nbits++;
        if (nbits == 8) begin
          nbits = 0;
          if (exp_q.size() > 0) check("spi_byte", {byte_dc, shreg}, exp_q.pop_front());
          else begin
            checks++;
            errors++;
            $error("FAIL spi_extra_byte: got %0h expected none", {byte_dc, shreg});
          end
        end
      end
      prev_sclk = sclk;
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_sclk", sclk, 0);
    check("rst_mosi", mosi, 0);
    check("rst_dc", dc, 0);
    check("rst_cs", cs, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 0;
    @(negedge clk);

    start_rect(9'd10, 9'd15, 9'd10, 9'd15, 16'hF800, 16'h0000, 1'b0, e);
    wait_done("fill", e, 1'b0);
    start_rect(9'd15, 9'd10, 9'd10, 9'd15, 16'hF800, 16'h0000, 1'b0, e);
    wait_done("swap", e, 1'b0);
    start_rect(9'd0, 9'd3, 9'd0, 9'd2, 16'hFFFF, 16'h0000, 1'b1, e);
    wait_done("outline", e, 1'b0);
    start_rect(9'd511, 9'd511, 9'd511, 9'd511, 16'h1234, 16'h0000, 1'b0, e);
    wait_done("single", e, 1'b0);

    start_rect(9'd0, 9'd3, 9'd0, 9'd3, 16'h07E0, 16'h0000, 1'b0, e);
    repeat (300) @(negedge clk);
    x1 = 9'd50; x2 = 9'd60; start = 1;
    @(negedge clk);
    start = 0;
    check("busy_mid_start", busy, 1);
    wait_done("ignore", e, 1'b1);
    check("done_cycle_start_busy", busy, 0);
    repeat (40) @(negedge clk);
    check("done_cycle_start_cs", cs, 1);
    check("no_extra_done", dones, 1);

    start_rect(9'd0, 9'd3, 9'd0, 9'd3, 16'h001F, 16'h0000, 1'b0, e);
    repeat (500) @(negedge clk);
    check("busy_before_rst", busy, 1);
    rst = 1;
    @(negedge clk);
    check("abort_cs", cs, 1);
    check("abort_sclk", sclk, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    rst = 0;
    exp_q.delete();
    repeat (30) @(negedge clk);
    check("abort_no_done", dones, 0);
    start_rect(9'd2, 9'd5, 9'd7, 9'd7, 16'hABCD, 16'h0000, 1'b1, e);
    wait_done("fresh", e, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
